// File: rtl/rr_fifo_arbiter.sv
// rtl/rr_fifo_arbiter.sv - round-robin burst arbiter feeding one shared write FIFO
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   req_valid      per-requester beat valid
//   req_data       per-requester beat data
//   req_ready      per-requester beat accepted
//   fifo_in_valid  write strobe to the shared FIFO
//   fifo_in_data   write data to the shared FIFO
//   fifo_in_src    requester index of the written beat
//   fifo_full      shared FIFO full flag
//   grant_active   high while a requester owns the FIFO
//   grant_idx      current or most recent granted requester

module rr_fifo_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BIT_WIDTH = 32,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                fifo_in_valid,
  output logic [BIT_WIDTH-1:0]                fifo_in_data,
  output logic [IDX_W-1:0]                    fifo_in_src,
  input  logic                                fifo_full,
  output logic                                grant_active,
  output logic [IDX_W-1:0]                    grant_idx
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] RESET_LAST  = IDX_W'(NUM_REQ - 1);

  state_t           state;
  logic [IDX_W-1:0] last_winner;
  logic [CNT_W-1:0] beat_cnt;

  logic             owner_valid;
  logic             beat_xfer;
  logic             any_req;
  logic [IDX_W-1:0] next_idx;
  int               cand;

  // Rotating priority search: the requester just after last_winner has
  // the highest priority, wrapping around past NUM_REQ-1 back to 0.
  always_comb begin
    any_req  = 1'b0;
    next_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_winner) + k) % NUM_REQ;
      if (!any_req && req_valid[IDX_W'(cand)]) begin
        any_req  = 1'b1;
        next_idx = IDX_W'(cand);
      end
    end
  end

  // Only the owner's valid matters during a grant; other requesters are
  // ignored until the arbiter is back in IDLE.
  assign owner_valid = req_valid[grant_idx];

  // Reset gates the handshake so nothing is written in the reset cycle,
  // even if a burst was in flight.
  assign beat_xfer = (state == GRANT) && owner_valid && !fifo_full && !rst;

  always_comb begin
    req_ready = '0;
    if ((state == GRANT) && !fifo_full && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign fifo_in_valid = beat_xfer;
  assign fifo_in_data  = req_data[grant_idx];
  assign fifo_in_src   = grant_idx;
  assign grant_active  = (state == GRANT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= RESET_LAST;
      grant_idx   <= '0;
      beat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (any_req) begin
            grant_idx <= next_idx;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_valid) begin
            // Owner finished early: hand the FIFO back.
            state       <= IDLE;
            last_winner <= grant_idx;
            beat_cnt    <= '0;
          end else if (beat_xfer) begin
            if (beat_cnt == LAST_BEAT) begin
              state       <= IDLE;
              last_winner <= grant_idx;
              beat_cnt    <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          // A full FIFO with valid still asserted simply holds everything.
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
